mult_div_unit: RTL and testbench

Multiply/divide unit for the MIPS datapath. Consumes the two register-file read ports (rs, rt) for mult/multu/div/divu/mthi/mtlo, holds the architectural HI/LO registers, and presents them for mfhi/mflo write-back into the register file. Multi-cycle latency is modelled with a busy counter so the controller can stall dependent HI/LO instructions.

---
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// MIPS HI/LO multiply/divide unit with a busy down-counter for controller stalls.
// Optional trace of HI/LO writes is compiled in with `define MDU_TRACE_EN.
module mult_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] WPC,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic               accept_md;
    logic               finish;
    logic               res_ok;
    logic [63:0]        res;
    logic signed [63:0] smul;
    logic [63:0]        umul;

    // 33-bit signed divide so 0x80000000 / -1 yields 0x80000000 rem 0 without overflow
    function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
        logic signed [32:0] ns, ds, q, r;
        ns = $signed({n[31], n});
        ds = $signed({d[31], d});
        q  = ns / ds;
        r  = ns % ds;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
        return {n % d, n / d};
    endfunction

    assign smul = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    assign umul = {32'b0, a_q} * {32'b0, b_q};

    always_comb begin
        res    = '0;
        res_ok = (op_q[1] == 1'b0) || (b_q != 32'b0);
        if (res_ok) begin
            case (op_q)
                2'b00:   res = smul;
                2'b01:   res = umul;
                2'b10:   res = div_signed(a_q, b_q);
                default: res = div_unsigned(a_q, b_q);
            endcase
        end
    end

    assign accept_md = (state_q == IDLE) && Start && (MDOp[2] == 1'b0);
    assign finish    = (state_q == RUN) && (cnt_q == 16'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept_md) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = MDOp[1:0];
                    cnt_d   = MDOp[1] ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
                    state_d = RUN;
                end else if (Start && MDOp == 3'b100) begin
                    hi_d = A;
                end else if (Start && MDOp == 3'b101) begin
                    lo_d = A;
                end
            end
            default: begin
                cnt_d = cnt_q - 16'd1;
                if (finish) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (res_ok) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operand latches carry no reset; they are only consumed in RUN
    always_ff @(posedge Clock) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
    end

`ifdef MDU_TRACE_EN
    logic [31:0] wpc_q, wpc_d;

    always_comb begin
        wpc_d = wpc_q;
        if (accept_md) wpc_d = WPC;
    end

    always_ff @(posedge Clock) begin
        wpc_q <= wpc_d;
        if (Reset) begin
            if (finish && res_ok) begin
                $display("@%08h: $hi <= %08h", wpc_q, res[63:32]);
                $display("@%08h: $lo <= %08h", wpc_q, res[31:0]);
            end else if (state_q == IDLE && Start && MDOp == 3'b100) begin
                $display("@%08h: $hi <= %08h", WPC, A);
            end else if (state_q == IDLE && Start && MDOp == 3'b101) begin
                $display("@%08h: $lo <= %08h", WPC, A);
            end
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^WPC;
`endif

    assign Busy = (state_q == RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with default latencies (5 / 10).
module tb_mult_div_unit;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [2:0]  MDOp  = 3'b000;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    logic [31:0] WPC   = 32'h0000_3000;
    logic        Busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .WPC(WPC), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        WPC   = WPC + 32'd4;
        step();
        Start = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0000_0000;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b, input int n,
                          input logic [31:0] hi_old, input logic [31:0] lo_old,
                          input logic [31:0] hi_new, input logic [31:0] lo_new);
        check_eq({tag, " busy issue"}, 32'(Busy), 32'd0);
        issue(op, a, b);
        for (int i = 1; i <= n; i++) begin
            check_eq({tag, " busy run"}, 32'(Busy), 32'd1);
            if (i == n) begin
                check_eq({tag, " hi hold"}, HI, hi_old);
                check_eq({tag, " lo hold"}, LO, lo_old);
            end
            step();
        end
        check_eq({tag, " busy done"}, 32'(Busy), 32'd0);
        check_eq({tag, " hi"}, HI, hi_new);
        check_eq({tag, " lo"}, LO, lo_new);
    endtask

    initial begin
        step();
        step();
        Reset = 1'b1;
        check_eq("reset hi", HI, 32'h0);
        check_eq("reset lo", LO, 32'h0);
        check_eq("reset busy", 32'(Busy), 32'd0);

        issue(3'b100, 32'h1111_1111, 32'h0);
        check_eq("mthi", HI, 32'h1111_1111);
        check_eq("mthi busy", 32'(Busy), 32'd0);
        issue(3'b101, 32'h2222_2222, 32'h0);
        check_eq("mtlo", LO, 32'h2222_2222);

        // reset two cycles into a mult
        issue(3'b000, 32'd3, 32'd5);
        step();
        Reset = 1'b0;
        step();
        step();
        Reset = 1'b1;
        check_eq("abort hi", HI, 32'h0);
        check_eq("abort lo", LO, 32'h0);
        check_eq("abort busy", 32'(Busy), 32'd0);
        for (int i = 0; i < 8; i++) step();
        check_eq("abort no late hi", HI, 32'h0);
        check_eq("abort no late lo", LO, 32'h0);

        issue(3'b110, 32'h5555_5555, 32'h1);
        check_eq("reserved busy", 32'(Busy), 32'd0);
        check_eq("reserved hi", HI, 32'h0);
        check_eq("reserved lo", LO, 32'h0);

        run_md("mult", 3'b000, 32'hFFFF_FFFE, 32'd3, 5,
               32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_md("multu", 3'b001, 32'hFFFF_FFFE, 32'd3, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0002, 32'hFFFF_FFFA);
        run_md("div", 3'b010, 32'hFFFF_FFF9, 32'd2, 10,
               32'h0000_0002, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu0", 3'b011, 32'd7, 32'd0, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("divu", 3'b011, 32'd100, 32'd7, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd2, 32'd14);

        // mtlo during RUN is dropped
        issue(3'b000, 32'd2, 32'd3);
        step();
        Start = 1'b1;
        MDOp  = 3'b101;
        A     = 32'h1234_5678;
        step();
        Start = 1'b0;
        check_eq("mtlo busy ignored", LO, 32'd14);
        check_eq("mtlo busy still busy", 32'(Busy), 32'd1);
        step();
        step();
        step();
        check_eq("mult2 busy", 32'(Busy), 32'd0);
        check_eq("mult2 hi", HI, 32'h0);
        check_eq("mult2 lo", LO, 32'd6);
        issue(3'b101, 32'h1234_5678, 32'h0);
        check_eq("mtlo idle", LO, 32'h1234_5678);
        check_eq("mtlo idle hi", HI, 32'h0);

        // overflow divide, then mult in cycle N (dropped) and N+1 (taken)
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        for (int i = 1; i < 10; i++) step();
        check_eq("ovf busy N", 32'(Busy), 32'd1);
        Start = 1'b1;
        MDOp  = 3'b000;
        A     = 32'd9;
        B     = 32'd9;
        step();
        Start = 1'b0;
        check_eq("ovf lo", LO, 32'h8000_0000);
        check_eq("ovf hi", HI, 32'h0);
        check_eq("ovf drop busy", 32'(Busy), 32'd0);
        run_md("mult after", 3'b000, 32'd5, 32'd7, 5,
               32'h0, 32'h8000_0000, 32'h0, 32'd35);

        run_md("mult negneg", 3'b000, 32'h8000_0000, 32'h8000_0000, 5,
               32'h0, 32'd35, 32'h4000_0000, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
